le18_port_arbiter: RTL and testbench

LE18_PORT_ARBITER -- requirements
Module: le18_port_arbiter

---
 rtl/le18_port_arbiter.sv | 124 ++++++++++++
 tb/tb_le18_port_arbiter.sv | 396 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/le18_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : le18_port_arbiter
// Description : LE18 RAM port-A arbiter. Z80 accesses have absolute priority
//               over a background full-RAM fill engine.
// Revision    : 1.0 - initial release
// ============================================================================
module le18_port_arbiter #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 6
) (
    input  logic              clk,
    input  logic              srst,
    input  logic              z80_req,
    input  logic              z80_we,
    input  logic [ADDR_W-1:0] z80_addr,
    input  logic [DATA_W-1:0] z80_wdata,
    output logic [DATA_W-1:0] z80_rdata,
    output logic              z80_rdy,
    input  logic              fill_start,
    input  logic              fill_abort,
    input  logic [DATA_W-1:0] fill_value,
    output logic              fill_busy,
    output logic              fill_done,
    output logic              ram_ce,
    output logic              ram_we,
    output logic              ram_oce,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_FILL = 1'b1
    } state_t;

    localparam logic [ADDR_W-1:0] C_LAST_ADDR = '1;

    state_t            r_state;
    logic [ADDR_W-1:0] r_fill_cnt;
    logic [DATA_W-1:0] r_fill_val;
    logic              r_rd_v1;
    logic              r_rd_done;
    logic [DATA_W-1:0] r_rdata_hold;

    // Read data is only valid on the RAM output during the completion cycle,
    // so it is forwarded combinationally then and held afterwards.
    assign z80_rdata = r_rd_done ? ram_dout : r_rdata_hold;

    always_ff @(posedge clk) begin
        if (srst) begin
            r_state      <= ST_IDLE;
            r_fill_cnt   <= '0;
            r_fill_val   <= '0;
            r_rd_v1      <= 1'b0;
            r_rd_done    <= 1'b0;
            r_rdata_hold <= '0;
            ram_ce       <= 1'b0;
            ram_we       <= 1'b0;
            ram_oce      <= 1'b0;
            ram_addr     <= '0;
            ram_din      <= '0;
            z80_rdy      <= 1'b0;
            fill_busy    <= 1'b0;
            fill_done    <= 1'b0;
        end else begin
            ram_ce    <= 1'b0;
            ram_we    <= 1'b0;
            fill_done <= 1'b0;

            // Read completion pipeline: ce -> oce -> data/rdy
            r_rd_v1   <= z80_req && !z80_we;
            ram_oce   <= r_rd_v1;
            r_rd_done <= ram_oce;
            z80_rdy   <= (z80_req && z80_we) || ram_oce;
            if (r_rd_done) begin
                r_rdata_hold <= ram_dout;
            end

            if (z80_req) begin
                ram_ce   <= 1'b1;
                ram_we   <= z80_we;
                ram_addr <= z80_addr;
                ram_din  <= z80_wdata;
            end else if (r_state == ST_FILL && !fill_abort) begin
                ram_ce   <= 1'b1;
                ram_we   <= 1'b1;
                ram_addr <= r_fill_cnt;
                ram_din  <= r_fill_val;
            end

            case (r_state)
                ST_IDLE: begin
                    if (fill_start && !fill_abort) begin
                        r_state    <= ST_FILL;
                        r_fill_cnt <= '0;
                        r_fill_val <= fill_value;
                        fill_busy  <= 1'b1;
                    end
                end
                ST_FILL: begin
                    if (fill_abort) begin
                        r_state   <= ST_IDLE;
                        fill_busy <= 1'b0;
                    end else if (!z80_req) begin
                        r_fill_cnt <= r_fill_cnt + 1'b1;
                        if (r_fill_cnt == C_LAST_ADDR) begin
                            r_state   <= ST_IDLE;
                            fill_busy <= 1'b0;
                            fill_done <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    fill_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_le18_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_le18_port_arbiter
// Description : Self-checking bench for le18_port_arbiter with a RAM model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_le18_port_arbiter;

    logic        clk = 1'b0;
    logic        srst;
    logic        z80_req;
    logic        z80_we;
    logic [13:0] z80_addr;
    logic [5:0]  z80_wdata;
    logic [5:0]  z80_rdata;
    logic        z80_rdy;
    logic        fill_start;
    logic        fill_abort;
    logic [5:0]  fill_value;
    logic        fill_busy;
    logic        fill_done;
    logic        ram_ce;
    logic        ram_we;
    logic        ram_oce;
    logic [13:0] ram_addr;
    logic [5:0]  ram_din;
    logic [5:0]  ram_dout = '0;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    typedef struct {
        int         due;
        logic       is_rd;
        logic [5:0] data;
    } exp_t;
    exp_t sb[$];

    le18_port_arbiter #(.ADDR_W(14), .DATA_W(6)) dut (
        .clk        (clk),
        .srst       (srst),
        .z80_req    (z80_req),
        .z80_we     (z80_we),
        .z80_addr   (z80_addr),
        .z80_wdata  (z80_wdata),
        .z80_rdata  (z80_rdata),
        .z80_rdy    (z80_rdy),
        .fill_start (fill_start),
        .fill_abort (fill_abort),
        .fill_value (fill_value),
        .fill_busy  (fill_busy),
        .fill_done  (fill_done),
        .ram_ce     (ram_ce),
        .ram_we     (ram_we),
        .ram_oce    (ram_oce),
        .ram_addr   (ram_addr),
        .ram_din    (ram_din),
        .ram_dout   (ram_dout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM model: ce at t, oce at t+1, dout valid at t+2
    logic [5:0] mem [0:16383];
    logic [5:0] rd_q = '0;
    always @(posedge clk) begin
        if (ram_ce && ram_we)  mem[ram_addr] <= ram_din;
        if (ram_ce && !ram_we) rd_q <= mem[ram_addr];
        if (ram_oce)           ram_dout <= rd_q;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        srst = 1'b1;
        tick();
        tick();
        compared++;
        if ({ram_ce, ram_we, ram_oce} !== 3'b000) begin
            mismatched++;
            $display("FAIL reset_ram_ctl: got %b want 000", {ram_ce, ram_we, ram_oce});
        end
        compared++;
        if ({z80_rdy, fill_busy, fill_done} !== 3'b000) begin
            mismatched++;
            $display("FAIL reset_flags: got %b want 000", {z80_rdy, fill_busy, fill_done});
        end
        compared++;
        if (z80_rdata !== 6'h00) begin
            mismatched++;
            $display("FAIL reset_rdata: got %h want 00", z80_rdata);
        end
        srst = 1'b0;
        tick();
    endtask

    task automatic test_write_read();
        z80_req = 1'b1; z80_we = 1'b1; z80_addr = 14'h1234; z80_wdata = 6'h2A;
        tick();
        compared++;
        if ({ram_ce, ram_we, ram_addr, ram_din, z80_rdy} !== {1'b1, 1'b1, 14'h1234, 6'h2A, 1'b1}) begin
            mismatched++;
            $display("FAIL wr_cycle1: got ce=%b we=%b a=%h d=%h rdy=%b want 1 1 1234 2a 1",
                     ram_ce, ram_we, ram_addr, ram_din, z80_rdy);
        end
        z80_we = 1'b0;
        tick();
        z80_req = 1'b0;
        compared++;
        if ({ram_ce, ram_we, ram_addr, z80_rdy} !== {1'b1, 1'b0, 14'h1234, 1'b0}) begin
            mismatched++;
            $display("FAIL rd_cycle1: got ce=%b we=%b a=%h rdy=%b want 1 0 1234 0",
                     ram_ce, ram_we, ram_addr, z80_rdy);
        end
        tick();
        compared++;
        if ({ram_oce, ram_ce, z80_rdy} !== 3'b100) begin
            mismatched++;
            $display("FAIL rd_cycle2: got oce/ce/rdy=%b want 100", {ram_oce, ram_ce, z80_rdy});
        end
        tick();
        compared++;
        if (z80_rdy !== 1'b1 || z80_rdata !== 6'h2A) begin
            mismatched++;
            $display("FAIL rd_cycle3: got rdy=%b data=%h want 1 2a", z80_rdy, z80_rdata);
        end
        tick();
        compared++;
        if (z80_rdy !== 1'b0 || z80_rdata !== 6'h2A) begin
            mismatched++;
            $display("FAIL rd_hold: got rdy=%b data=%h want 0 2a", z80_rdy, z80_rdata);
        end
    endtask

    task automatic test_back_to_back();
        logic [13:0] a;
        int          idx;
        sb.delete();
        for (int n = 0; n < 10; n++) begin
            if (n < 6) begin
                idx = n % 3;
                a = 14'h0100 + 14'(idx);
                z80_req = 1'b1;
                z80_we = (n < 3);
                z80_addr = a;
                z80_wdata = 6'(idx + 1);
                sb.push_back('{cyc + ((n < 3) ? 1 : 3), (n >= 3), 6'(idx + 1)});
            end else begin
                z80_req = 1'b0;
            end
            tick();
            if (sb.size() > 0 && sb[0].due == cyc) begin
                compared++;
                if (z80_rdy !== 1'b1 || (sb[0].is_rd && z80_rdata !== sb[0].data)) begin
                    mismatched++;
                    $display("FAIL b2b_done cyc %0d: got rdy=%b data=%h want 1 %h",
                             cyc, z80_rdy, z80_rdata, sb[0].data);
                end
                void'(sb.pop_front());
            end else begin
                compared++;
                if (z80_rdy !== 1'b0) begin
                    mismatched++;
                    $display("FAIL b2b_idle cyc %0d: got rdy=%b want 0", cyc, z80_rdy);
                end
            end
        end
        compared++;
        if (sb.size() != 0) begin
            mismatched++;
            $display("FAIL b2b_pending: got %0d outstanding want 0", sb.size());
        end
    endtask

    task automatic test_fill_full();
        int wr = 0, bad = 0, busy_cyc = 0, done_cnt = 0, stray = 0;
        fill_value = 6'h3F; fill_start = 1'b1;
        tick();
        fill_start = 1'b0;
        compared++;
        if (fill_busy !== 1'b1) begin
            mismatched++;
            $display("FAIL fill_busy_rise: got %b want 1", fill_busy);
        end
        for (int n = 0; n < 20000; n++) begin
            if (fill_busy) busy_cyc++;
            // restart attempt while filling must be ignored
            fill_start = (n == 50);
            fill_value = (n == 50) ? 6'h01 : 6'h3F;
            tick();
            if (ram_ce) begin
                if (!ram_we || ram_oce || ram_addr !== 14'(wr) || ram_din !== 6'h3F) bad++;
                wr++;
            end
            if (fill_done) begin
                done_cnt++;
                if (fill_busy !== 1'b0) bad++;
            end
            if (!fill_busy) break;
        end
        fill_start = 1'b0;
        for (int n = 0; n < 4; n++) begin
            tick();
            if (ram_ce || fill_done || fill_busy) stray++;
        end
        compared++;
        if (wr != 16384 || bad != 0) begin
            mismatched++;
            $display("FAIL fill_writes: got %0d writes %0d bad want 16384 0", wr, bad);
        end
        compared++;
        if (busy_cyc != 16384) begin
            mismatched++;
            $display("FAIL fill_duration: got %0d want 16384", busy_cyc);
        end
        compared++;
        if (done_cnt != 1 || stray != 0) begin
            mismatched++;
            $display("FAIL fill_done: got done=%0d stray=%0d want 1 0", done_cnt, stray);
        end
    endtask

    task automatic test_fill_z80();
        int          wr = 0, bad_order = 0, bad_rdy = 0, bad_ce = 0;
        int          busy_cyc = 0, done_cnt = 0, nacc = 0;
        logic        pend;
        logic [13:0] paddr, a;
        pend = 1'b0;
        paddr = '0;
        sb.delete();
        fill_value = 6'h15; fill_start = 1'b1;
        tick();
        fill_start = 1'b0;
        for (int n = 0; n < 25000; n++) begin
            if (fill_busy) busy_cyc++;
            if (fill_busy && (n % 5 == 4)) begin
                a = (nacc % 2 == 1) ? 14'(nacc) : 14'(16383 - nacc);
                z80_req = 1'b1; z80_we = 1'b0; z80_addr = a;
                sb.push_back('{cyc + 3, 1'b1, (int'(a) < wr) ? 6'h15 : 6'h3F});
                pend = 1'b1; paddr = a;
                nacc++;
            end else begin
                z80_req = 1'b0;
            end
            tick();
            if (pend) begin
                if (!(ram_ce && !ram_we && ram_addr == paddr)) bad_ce++;
                pend = 1'b0;
            end
            if (ram_ce && ram_we) begin
                if (ram_addr !== 14'(wr) || ram_din !== 6'h15) bad_order++;
                wr++;
            end
            if (sb.size() > 0 && sb[0].due == cyc) begin
                if (z80_rdy !== 1'b1 || z80_rdata !== sb[0].data) bad_rdy++;
                void'(sb.pop_front());
            end else if (z80_rdy !== 1'b0) begin
                bad_rdy++;
            end
            if (fill_done) begin
                done_cnt++;
                if (fill_busy !== 1'b0) bad_order++;
            end
            if (!fill_busy && sb.size() == 0) break;
        end
        z80_req = 1'b0;
        compared++;
        if (bad_ce != 0 || bad_rdy != 0 || sb.size() != 0) begin
            mismatched++;
            $display("FAIL fz_reads: got bad_ce=%0d bad_rdy=%0d pending=%0d want 0 0 0",
                     bad_ce, bad_rdy, sb.size());
        end
        compared++;
        if (wr != 16384 || bad_order != 0) begin
            mismatched++;
            $display("FAIL fz_writes: got %0d writes %0d bad want 16384 0", wr, bad_order);
        end
        compared++;
        if (busy_cyc != 16384 + nacc || done_cnt != 1) begin
            mismatched++;
            $display("FAIL fz_duration: got %0d cycles done=%0d want %0d 1",
                     busy_cyc, done_cnt, 16384 + nacc);
        end
    endtask

    task automatic test_abort();
        int wr = 0, stray = 0;
        // start and abort together in IDLE: nothing starts
        fill_value = 6'h0A; fill_start = 1'b1; fill_abort = 1'b1;
        tick();
        fill_start = 1'b0; fill_abort = 1'b0;
        tick();
        compared++;
        if (fill_busy !== 1'b0 || ram_ce !== 1'b0) begin
            mismatched++;
            $display("FAIL abort_start_idle: got busy=%b ce=%b want 0 0", fill_busy, ram_ce);
        end
        fill_start = 1'b1;
        tick();
        fill_start = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if (wr == 100) break;
            tick();
            if (ram_ce && ram_we) wr++;
        end
        fill_abort = 1'b1;
        tick();
        fill_abort = 1'b0;
        if (ram_ce && ram_we) wr++;
        compared++;
        if (fill_busy !== 1'b0) begin
            mismatched++;
            $display("FAIL abort_busy: got %b want 0", fill_busy);
        end
        for (int n = 0; n < 6; n++) begin
            tick();
            if (ram_ce || fill_done || fill_busy) stray++;
        end
        compared++;
        if (wr < 100 || wr > 101 || stray != 0) begin
            mismatched++;
            $display("FAIL abort_stop: got writes=%0d stray=%0d want 100..101 0", wr, stray);
        end
    endtask

    task automatic test_srst_mid();
        int stray = 0;
        z80_req = 1'b1; z80_we = 1'b0; z80_addr = 14'h0055;
        tick();
        z80_req = 1'b0;
        tick();
        compared++;
        if (ram_oce !== 1'b1) begin
            mismatched++;
            $display("FAIL srst_rd_oce: got %b want 1", ram_oce);
        end
        srst = 1'b1;
        tick();
        srst = 1'b0;
        compared++;
        if ({z80_rdy, ram_ce, ram_we, ram_oce} !== 4'b0000 || z80_rdata !== 6'h00) begin
            mismatched++;
            $display("FAIL srst_rd: got rdy/ce/we/oce=%b data=%h want 0000 00",
                     {z80_rdy, ram_ce, ram_we, ram_oce}, z80_rdata);
        end
        fill_value = 6'h07; fill_start = 1'b1;
        tick();
        fill_start = 1'b0;
        for (int n = 0; n < 20; n++) tick();
        srst = 1'b1;
        tick();
        srst = 1'b0;
        compared++;
        if ({fill_busy, ram_ce, ram_we, ram_oce} !== 4'b0000) begin
            mismatched++;
            $display("FAIL srst_fill: got busy/ce/we/oce=%b want 0000",
                     {fill_busy, ram_ce, ram_we, ram_oce});
        end
        for (int n = 0; n < 8; n++) begin
            tick();
            if (ram_ce || fill_done || fill_busy || z80_rdy) stray++;
        end
        compared++;
        if (stray != 0) begin
            mismatched++;
            $display("FAIL srst_quiet: got %0d active cycles want 0", stray);
        end
    endtask

    initial begin
        srst = 1'b1; z80_req = 1'b0; z80_we = 1'b0; z80_addr = '0; z80_wdata = '0;
        fill_start = 1'b0; fill_abort = 1'b0; fill_value = '0;
        test_reset();
        test_write_read();
        test_back_to_back();
        test_fill_full();
        test_fill_z80();
        test_abort();
        test_srst_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
